// File: rtl/priority_encoder_stream_if.sv
// Handshake bundle for priority_encoder_stream.
// master: request-vector producer / index consumer side; slave: the encoder.
interface priority_encoder_stream_if #(
  parameter int unsigned WIDTH = 4
) ();
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [IDX_W-1:0] out_beat;
  logic             zero_drop;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_beat, zero_drop
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_beat, zero_drop
  );
endinterface

// File: rtl/priority_encoder_stream.sv
// priority_encoder_stream: accepts a WIDTH-bit request vector and emits the
// index of every set bit, one per output handshake.
// Optional macro PRIENC_MSB_FIRST_EN: emit indices highest bit first
// (default: lowest bit first).
module priority_encoder_stream #(
  parameter int unsigned WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  priority_encoder_stream_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] res;
  logic [IDX_W-1:0] beat;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_q;
  logic             drop_q;
  logic             ready_q;
  logic [WIDTH-1:0] res_nx;

  // Index of the bit the scan selects next; 0 for an empty vector.
  function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
`ifdef PRIENC_MSB_FIRST_EN
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i]) r = IDX_W'(i);
    end
`else
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
`endif
    return r;
  endfunction

  // True when exactly one bit is set.
  function automatic logic single(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // Residual after retiring the currently presented index.
  always_comb begin
    res_nx = res & ~(WIDTH'(1) << idx_q);
  end

  // Scan FSM with registered beat outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      res     <= '0;
      beat    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && ready_q) begin
            if (bus.in_vec == '0) begin
              drop_q <= 1'b1;
            end else begin
              res     <= bus.in_vec;
              beat    <= '0;
              valid_q <= 1'b1;
              idx_q   <= pick(bus.in_vec);
              last_q  <= single(bus.in_vec);
              ready_q <= 1'b0;
              state   <= SCAN;
            end
          end
        end
        SCAN: begin
          if (bus.out_ready) begin
            res    <= res_nx;
            beat   <= beat + IDX_W'(1);
            idx_q  <= pick(res_nx);
            last_q <= single(res_nx);
            if (last_q) begin
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          res     <= '0;
          beat    <= '0;
          valid_q <= 1'b0;
          idx_q   <= '0;
          last_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Ready is forced low while reset is held.
  assign bus.in_ready  = ready_q & ~rst;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_beat  = beat;
  assign bus.zero_drop = drop_q;

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Randomised self-checking bench for priority_encoder_stream.
module tb_priority_encoder_stream;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  priority_encoder_stream_if #(.WIDTH(WIDTH)) bus ();

  priority_encoder_stream #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference order of indices for a vector.
  function automatic void expected_order(input logic [WIDTH-1:0] v, output int q[$]);
    q = {};
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i]) begin
`ifdef PRIENC_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
  endfunction

  // Send one vector and consume all its beats; entered and left at a negedge.
  task automatic run_vec(input logic [WIDTH-1:0] v, input int first_stall, input bit rand_stall);
    int q[$];
    int stalls;
    int rstalls;
    bit done;
    expected_order(v, q);
    check("idle_in_ready", int'(bus.in_ready), 1);
    check("idle_out_valid", int'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_vec   = WIDTH'($urandom);
    if (q.size() == 0) begin
      check("zero_drop", int'(bus.zero_drop), 1);
      check("zero_out_valid", int'(bus.out_valid), 0);
      check("zero_in_ready", int'(bus.in_ready), 1);
    end else begin
      check("accept_zero_drop", int'(bus.zero_drop), 0);
      for (int j = 0; j < q.size(); j++) begin
        stalls  = (j == 0) ? first_stall : 0;
        rstalls = 0;
        done    = 1'b0;
        while (!done) begin
          check("out_valid", int'(bus.out_valid), 1);
          check("out_idx", int'(bus.out_idx), q[j]);
          check("out_last", int'(bus.out_last), (j == q.size() - 1) ? 1 : 0);
          check("out_beat", int'(bus.out_beat), j);
          check("scan_in_ready", int'(bus.in_ready), 0);
          if (stalls > 0) begin
            bus.out_ready = 1'b0;
            stalls--;
          end else if (rand_stall && rstalls < 8 && ($urandom % 4) == 0) begin
            bus.out_ready = 1'b0;
            rstalls++;
          end else begin
            bus.out_ready = 1'b1;
            done = 1'b1;
          end
          bus.in_vec = WIDTH'($urandom);
          @(negedge clk);
        end
      end
      check("end_out_valid", int'(bus.out_valid), 0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    int exp_first;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_zero_drop", int'(bus.zero_drop), 0);
    check("rst_out_idx", int'(bus.out_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);

    run_vec(4'b1011, 0, 1'b0);
    run_vec(4'b1000, 0, 1'b0);
    run_vec(4'b0110, 3, 1'b0);
    run_vec(4'b0000, 0, 1'b0);
    run_vec(4'b0000, 0, 1'b0);

    // Reset in the middle of a scan.
    bus.in_valid  = 1'b1;
    bus.in_vec    = 4'b1111;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef PRIENC_MSB_FIRST_EN
    exp_first = 3;
`else
    exp_first = 0;
`endif
    check("mid_first_idx", int'(bus.out_idx), exp_first);
    @(negedge clk);
    @(negedge clk);
    check("mid_third_beat", int'(bus.out_beat), 2);
    rst = 1'b1;
    #1;
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_in_ready", int'(bus.in_ready), 0);
    check("arst_out_idx", int'(bus.out_idx), 0);
    check("arst_out_last", int'(bus.out_last), 0);
    check("arst_out_beat", int'(bus.out_beat), 0);
    check("arst_zero_drop", int'(bus.zero_drop), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    run_vec(4'b0001, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      v = WIDTH'($urandom);
      run_vec(v, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
